// File: rtl/operand_loader.sv
// Keyboard operand loader: parses two decimal operands from ASCII characters.
// It presents the X/Y pair to a downstream adder with a valid/ready handshake.
module operand_loader #(
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     char_in,
    input  logic           char_valid,
    output logic           char_ready,
    output logic [OPW-1:0] X,
    output logic [OPW-1:0] Y,
    output logic           opnd_valid,
    input  logic           opnd_ready,
    output logic           err
);

    localparam int AW = OPW + 4;
    localparam logic [AW+3:0] MAX_VAL = {{(8){1'b0}}, {OPW{1'b1}}};

    typedef enum logic [1:0] {
        GET_X   = 2'd0,
        GET_Y   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CH_DIGIT,
        CH_ENTER,
        CH_OTHER
    } char_class_t;

    state_t          state_q, state_d;
    logic [OPW-1:0]  x_q, x_d;
    logic [OPW-1:0]  y_q, y_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            dseen_q, dseen_d;
    logic            ovf_q, ovf_d;
    logic            opnd_valid_q, opnd_valid_d;
    logic            err_q, err_d;

    char_class_t     char_class;
    logic [3:0]      digit;
    logic [AW+3:0]   acc_wide;
    logic            accept;
    logic            too_big;

    // Reset forces char_ready low so nothing is consumed on a reset edge.
    assign char_ready = (state_q != PRESENT) && !rst;
    assign accept     = char_valid && char_ready;

    always_comb begin
        char_class = CH_OTHER;
        digit      = char_in[3:0];
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            char_class = CH_DIGIT;
        end else if (char_in == 8'h0A || char_in == 8'h0D) begin
            char_class = CH_ENTER;
        end
    end

    // acc*10 + digit, computed wide enough that the overflow compare sees every bit.
    always_comb begin
        acc_wide = {1'b0, acc_q, 3'b000} + {3'b000, acc_q, 1'b0} + {{AW{1'b0}}, digit};
        too_big  = (acc_wide > MAX_VAL);
    end

    // NOTE: every signal written here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        dseen_d = dseen_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;

        if (accept) begin
            unique case (char_class)
                CH_DIGIT: begin
                    if (!ovf_q) begin
                        acc_d   = acc_wide[AW-1:0];
                        dseen_d = 1'b1;
                        if (too_big) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                CH_ENTER: begin
                    if (dseen_q) begin
                        acc_d   = '0;
                        dseen_d = 1'b0;
                        ovf_d   = 1'b0;
                        if (ovf_q) begin
                            err_d = 1'b1;
                        end else if (state_q == GET_X) begin
                            x_d     = acc_q[OPW-1:0];
                            state_d = GET_Y;
                        end else begin
                            y_d     = acc_q[OPW-1:0];
                            state_d = PRESENT;
                        end
                    end
                end
                default: begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    dseen_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            endcase
        end

        if (opnd_valid_q && opnd_ready) begin
            state_d = GET_X;
        end

        opnd_valid_d = (state_d == PRESENT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GET_X;
            x_q          <= '0;
            y_q          <= '0;
            acc_q        <= '0;
            dseen_q      <= 1'b0;
            ovf_q        <= 1'b0;
            opnd_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            acc_q        <= acc_d;
            dseen_q      <= dseen_d;
            ovf_q        <= ovf_d;
            opnd_valid_q <= opnd_valid_d;
            err_q        <= err_d;
        end
    end

    assign X          = x_q;
    assign Y          = y_q;
    assign opnd_valid = opnd_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed scenarios plus random
// character streams compared against a value-level reference model.
module tb_operand_loader;

    localparam int OPW  = 5;
    localparam int MAXV = (1 << OPW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     char_in = 8'h00;
    logic           char_valid = 1'b0;
    logic           char_ready;
    logic [OPW-1:0] X;
    logic [OPW-1:0] Y;
    logic           opnd_valid;
    logic           opnd_ready = 1'b0;
    logic           err;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = waiting for X, 1 = waiting for Y, 2 = presenting.
    int m_phase = 0;
    int m_x     = 0;
    int m_y     = 0;
    int m_val   = 0;
    bit m_seen  = 0;
    bit m_over  = 0;
    bit m_err   = 0;

    operand_loader #(.OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .X          (X),
        .Y          (Y),
        .opnd_valid (opnd_valid),
        .opnd_ready (opnd_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_val  = 0;
        m_seen = 0;
        m_over = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_x"},     X, m_x);
        chk({tag, "_y"},     Y, m_y);
        chk({tag, "_valid"}, opnd_valid, (m_phase == 2));
        chk({tag, "_err"},   err, m_err);
    endtask

    // One clock cycle with the given inputs; the model advances at the edge.
    task automatic step(input logic [7:0] c, input logic v, input logic r, input string tag);
        bit accepted;
        bit handshake;
        @(negedge clk);
        char_in    = c;
        char_valid = v;
        opnd_ready = r;
        #1;
        chk({tag, "_crdy"}, char_ready, (m_phase != 2));
        accepted  = v && (m_phase != 2);
        handshake = (m_phase == 2) && r;
        @(posedge clk);
        m_err = 0;
        if (accepted) begin
            if (c >= 8'h30 && c <= 8'h39) begin
                if (!m_over) begin
                    m_val  = m_val * 10 + int'(c) - 48;
                    m_seen = 1;
                    if (m_val > MAXV) m_over = 1;
                end
            end else if (c == 8'h0A || c == 8'h0D) begin
                if (m_seen) begin
                    if (m_over) begin
                        m_err = 1;
                    end else if (m_phase == 0) begin
                        m_x     = m_val;
                        m_phase = 1;
                    end else begin
                        m_y     = m_val;
                        m_phase = 2;
                    end
                    model_clear();
                end
            end else begin
                m_err = 1;
                model_clear();
            end
        end
        if (handshake) m_phase = 0;
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input logic v, input logic [7:0] c, input string tag);
        @(negedge clk);
        rst        = 1'b1;
        char_in    = c;
        char_valid = v;
        opnd_ready = 1'b1;
        #1;
        chk({tag, "_crdy_in_rst"}, char_ready, 0);
        @(posedge clk);
        m_phase = 0;
        m_x     = 0;
        m_y     = 0;
        m_err   = 0;
        model_clear();
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst        = 1'b0;
        char_valid = 1'b0;
        opnd_ready = 1'b0;
    endtask

    task automatic send(input string s, input logic r, input string tag);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1'b1, r, tag);
        end
    endtask

    initial begin
        // Reset with a character and a handshake offered at the same time.
        do_reset(1'b1, 8'h35, "reset0");

        // 17 / 29, downstream always ready: one-cycle opnd_valid.
        send("17\n29\n", 1'b1, "s1");
        chk("s1_pair_x", X, 17);
        chk("s1_pair_y", Y, 29);
        chk("s1_pair_valid", opnd_valid, 1);
        step(8'h00, 1'b0, 1'b1, "s1_hs");
        chk("s1_back_valid", opnd_valid, 0);
        chk("s1_back_ready", char_ready, 1);

        // Overflow on Enter is rejected, then a legal 31.
        send("32\n", 1'b0, "s2a");
        chk("s2_err_pulse", err, 1);
        chk("s2_x_held", X, 17);
        step(8'h00, 1'b0, 1'b0, "s2_idle");
        send("31\n", 1'b0, "s2b");
        chk("s2_x31", X, 31);

        // Bare Enter ignored; leading zeros legal (fresh start after reset).
        do_reset(1'b0, 8'h00, "reset1");
        send("\n", 1'b0, "s3a");
        chk("s3_no_err", err, 0);
        send("005\n", 1'b0, "s3b");
        chk("s3_x5", X, 5);

        // Junk character inside a Y entry.
        send("1a", 1'b0, "s4a");
        chk("s4_err_on_a", err, 1);
        send("4\n", 1'b0, "s4b");
        chk("s4_y4", Y, 4);
        chk("s4_present", opnd_valid, 1);

        // Back-pressure while presenting, characters offered all along.
        for (int i = 0; i < 5; i++) step(8'h37, 1'b1, 1'b0, "s5_hold");
        chk("s5_x_stable", X, 5);
        chk("s5_y_stable", Y, 4);
        step(8'h37, 1'b1, 1'b1, "s5_hs");
        chk("s5_ready_back", char_ready, 1);

        // Reset mid-entry discards the partial digit.
        send("1", 1'b0, "s6a");
        do_reset(1'b1, 8'h31, "s6_rst");
        send("5\n", 1'b0, "s6b");
        chk("s6_x5_not15", X, 5);

        // Random traffic, mostly small digits so legal operands occur often.
        do_reset(1'b0, 8'h00, "reset2");
        for (int n = 0; n < 1500; n++) begin
            int sel;
            logic [7:0] c;
            sel = $urandom_range(0, 19);
            if (sel < 10)      c = 8'h30 + 8'($urandom_range(0, 3));
            else if (sel < 12) c = 8'h30 + 8'($urandom_range(4, 9));
            else if (sel < 17) c = ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h0D;
            else if (sel < 19) c = 8'h61 + 8'($urandom_range(0, 25));
            else               c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 1) != 0, c, "rnd_rst");
            end else begin
                step(c, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
